fsm_transition_monitor: RTL and testbench
=========================================

# fsm_transition_monitor

Passive observer on the consuming side of a generated FSM's `state`/`next_state` outputs. It detects every state transition and packs each one into a record: from-state, to-state and dwell time. Records are buffered in a small FIFO and drained over a valid/ready stream to trace or debug logic. It also flags an FSM that stays in one state for too long.

## Interface
Parameters:
- `STATE_W`, default 2: width of the observed state encoding.
- `DEPTH`, default 8: record FIFO depth; power of two, at least 2.
- `TS_W`, default 16: dwell counter and `rec_delta` width.
- `STUCK_LIMIT`, default 1024: dwell cycles before `stuck` asserts; at least 1 and below 2^TS_W.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- `state` in STATE_W: observed FSM's current state register.
- `next_state` in STATE_W: observed FSM's combinational next state.
- `clear` in 1: synchronous clear of `overflow`, `drop_count` and `stuck` only.
- `rec_valid` out 1: head record is valid.
- `rec_ready` in 1: consumer accepts the head record.
- `rec_from` out STATE_W: state left.
- `rec_to` out STATE_W: state entered.
- `rec_delta` out TS_W: cycles spent in `rec_from`, saturating.
- `overflow` out 1: sticky; at least one record has been dropped.
- `drop_count` out 8: dropped records, saturating at 255.
- `stuck` out 1: FSM has held one state for at least STUCK_LIMIT cycles.

## Operation
- Transition event: a rising `clk` edge with `rst`=0 and `next_state != state`. Inputs are sampled at that edge.
- Dwell counter `dwell`:
  - Cleared to 0 by reset and by every event.
  - Otherwise increments by 1 per cycle, saturating at 2^TS_W-1.
- Record fields per event:
  - `from` = `state`.
  - `to` = `next_state`.
  - `delta` = `dwell`+1, saturating at all-ones.
- Push: each event writes one record into the FIFO.
- Pop: occurs when `rec_valid && rec_ready`.
- Full FIFO:
  - A push without a simultaneous pop is dropped.
  - The drop sets `overflow` and increments `drop_count` (saturating).
  - A push with a simultaneous pop while full is accepted, and occupancy is unchanged.
- Empty FIFO with a simultaneous push and pop: not possible, because `rec_valid`=0. The push is stored.
- Stuck FSM, two states:
  - RUN → STUCK when `dwell` reaches STUCK_LIMIT-1 with no event. `stuck` is then asserted from the next cycle.
  - STUCK → RUN on the next event.
  - `clear` forces RUN for the current dwell period only; it does not re-arm until the next event.
- `clear` and a drop on the same edge: the drop wins, giving `overflow`=1 and `drop_count`=1.
- Outputs are stable while `rec_valid`=1 and `rec_ready`=0.
- Reset values: `rec_valid`=0, `rec_from`=0, `rec_to`=0, `rec_delta`=0, `overflow`=0, `drop_count`=0, `stuck`=0. The FIFO is emptied, `dwell`=0 and the stuck FSM is in RUN.
- Reset mid-operation discards all buffered records. No events are recorded on edges where `rst`=1.

## Timing
- Event to `rec_valid` (empty FIFO): 1 cycle, registered.
- Back-to-back events every cycle are recorded until the FIFO is full.
- Sustained throughput: 1 record per cycle with `rec_ready` held at 1.
- All outputs are registered. There is no combinational path from `rec_ready` to any output.
- `stuck` asserts exactly STUCK_LIMIT cycles after the last event (or after reset release).

## Configuration
- `FSM_MONITOR_TIMESTAMP_EN` defined:
  - Dwell counter, `rec_delta` field and stuck FSM are built.
  - Records are 2·STATE_W+TS_W bits wide.
- `FSM_MONITOR_TIMESTAMP_EN` undefined:
  - No counter or stuck logic is built.
  - `rec_delta` and `stuck` are tied to 0.
  - Records are 2·STATE_W bits wide.
  - All other behaviour is identical.

## Structure
- Shared package `fsm_monitor_pkg` holds:
  - the `fsm_trans_rec_t` packed struct (from/to/delta);
  - the `stuck_state_e` enum (RUN, STUCK);
  - the saturation constant for `drop_count`.
- One sub-module, `fsm_monitor_fifo`: a parameterised synchronous FIFO of `fsm_trans_rec_t`. It has push/pop/full/empty and a registered head output.

## Test plan
- Transition after a 5-cycle dwell: with `state`=0 and `next_state` going to 1 after 5 cycles, expect one record {from 0, to 1, delta 5}, with `rec_valid` one cycle after the edge.
- Burst with backpressure: ten single-cycle transitions 0→1→2→3→0…, DEPTH=8, `rec_ready`=0. Expect eight records held, `overflow`=1 and `drop_count`=2. Then drain with `rec_ready`=1 and expect the first eight records in order, each with delta=1.
- Full FIFO with a simultaneous push and pop: the new record is accepted, `drop_count` is unchanged and occupancy stays at 8.
- Stuck detection: STUCK_LIMIT=16, no transitions after reset. Expect `stuck`=1 at cycle 16. Then a transition 2→3 clears `stuck` and gives a record whose delta is the full dwell.
- Reset mid-stream: 3 records buffered, then `rst` pulsed for 1 cycle. Expect `rec_valid`=0, counters 0, and no record for a transition presented during reset.
- Macro undefined: repeat the first test and expect {0, 1, delta 0}, with `stuck` never asserting.

Source files
------------

// File: rtl/fsm_monitor_pkg.sv
// Shared types for the FSM transition monitor: record layout, stuck-detector states
// and the drop counter ceiling. FSM_MONITOR_TIMESTAMP_EN adds the delta field.
package fsm_monitor_pkg;

  localparam int DEF_STATE_W = 2;
  localparam int DEF_TS_W    = 16;

  localparam int         DROP_CNT_W   = 8;
  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

  typedef enum logic {
    RUN   = 1'b0,
    STUCK = 1'b1
  } stuck_state_e;

  typedef struct packed {
    logic [DEF_STATE_W-1:0] from;
    logic [DEF_STATE_W-1:0] to;
`ifdef FSM_MONITOR_TIMESTAMP_EN
    logic [DEF_TS_W-1:0]    delta;
`endif
  } fsm_trans_rec_t;

endpackage

// File: rtl/fsm_monitor_fifo.sv
// Synchronous record FIFO with a registered head: head and empty come straight from flops,
// so nothing on the read side is combinational from pop.
module fsm_monitor_fifo
  import fsm_monitor_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type rec_t = fsm_trans_rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rec_t din,
  input  logic pop,
  output logic full,
  output logic empty,
  output rec_t head
);

  localparam int PTR_W = $clog2(DEPTH);

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [PTR_W:0]   count;
  logic [PTR_W:0]   count_nxt;
  logic             push_acc;
  logic             bypass;
  rec_t             head_nxt;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign push_acc = push && (!full || pop);
  // The incoming record becomes the head when it lands in an otherwise drained FIFO.
  assign bypass   = push_acc && (count == (PTR_W+1)'(pop));

  always_comb begin
    count_nxt  = count + (PTR_W+1)'(push_acc) - (PTR_W+1)'(pop);
    rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    head_nxt   = head;
    if (count_nxt != '0) begin
      if (bypass) head_nxt = din;
      else        head_nxt = mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      head   <= '0;
    end else begin
      count  <= count_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      empty  <= (count_nxt == '0);
      head   <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fsm_transition_monitor.sv
// Passive monitor of an FSM's state/next_state: records each transition into a FIFO
// and flags long dwells. FSM_MONITOR_TIMESTAMP_EN builds the dwell counter and stuck flag.
module fsm_transition_monitor
  import fsm_monitor_pkg::*;
#(
  parameter int STATE_W     = 2,
  parameter int DEPTH       = 8,
  parameter int TS_W        = 16,
  parameter int STUCK_LIMIT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] state,
  input  logic [STATE_W-1:0] next_state,
  input  logic               clear,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [STATE_W-1:0] rec_from,
  output logic [STATE_W-1:0] rec_to,
  output logic [TS_W-1:0]    rec_delta,
  output logic               overflow,
  output logic [7:0]         drop_count,
  output logic               stuck
);

  typedef struct packed {
    logic [STATE_W-1:0] from;
    logic [STATE_W-1:0] to;
`ifdef FSM_MONITOR_TIMESTAMP_EN
    logic [TS_W-1:0]    delta;
`endif
  } rec_t;

  logic evt_p0;
  logic pop_p0;
  logic drop_p0;
  logic full_p0;
  logic empty_p1;
  rec_t rec_p0;
  rec_t head_p1;

  // Stage p0: event detection on the observed FSM's inputs
  assign evt_p0  = !rst && (next_state != state);
  assign pop_p0  = rec_valid && rec_ready;
  assign drop_p0 = evt_p0 && full_p0 && !pop_p0;

`ifdef FSM_MONITOR_TIMESTAMP_EN
  localparam logic [TS_W-1:0] STUCK_AT = TS_W'(STUCK_LIMIT - 1);

  logic [TS_W-1:0] dwell_p0;
  logic            stuck_arm_q;
  stuck_state_e    stuck_q;
  stuck_state_e    stuck_nxt;

  function automatic logic [TS_W-1:0] sat_inc(input logic [TS_W-1:0] v);
    return (v == '1) ? v : v + TS_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || evt_p0) dwell_p0 <= '0;
    else               dwell_p0 <= sat_inc(dwell_p0);
  end

  // A clear silences the detector for the remainder of the current dwell period.
  always_ff @(posedge clk) begin
    if (rst || evt_p0) stuck_arm_q <= 1'b1;
    else if (clear)    stuck_arm_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) stuck_q <= RUN;
    else     stuck_q <= stuck_nxt;
  end

  always_comb begin
    stuck_nxt = stuck_q;
    case (stuck_q)
      RUN:     if (!evt_p0 && !clear && stuck_arm_q && (dwell_p0 == STUCK_AT)) stuck_nxt = STUCK;
      STUCK:   if (evt_p0 || clear) stuck_nxt = RUN;
      default: stuck_nxt = RUN;
    endcase
  end

  always_comb begin
    stuck = (stuck_q == STUCK);
  end

  always_comb begin
    rec_p0.from  = state;
    rec_p0.to    = next_state;
    rec_p0.delta = sat_inc(dwell_p0);
  end

  assign rec_delta = head_p1.delta;
`else
  always_comb begin
    rec_p0.from = state;
    rec_p0.to   = next_state;
  end

  assign rec_delta = '0;
  assign stuck     = 1'b0;
`endif

  // Stage p1: buffered records, head registered inside the FIFO
  fsm_monitor_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt_p0),
    .din   (rec_p0),
    .pop   (pop_p0),
    .full  (full_p0),
    .empty (empty_p1),
    .head  (head_p1)
  );

  assign rec_valid = !empty_p1;
  assign rec_from  = head_p1.from;
  assign rec_to    = head_p1.to;

  // A drop coinciding with clear counts as the first drop after the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      overflow   <= drop_p0;
      drop_count <= drop_p0 ? 8'd1 : 8'd0;
    end else if (drop_p0) begin
      overflow <= 1'b1;
      if (drop_count != DROP_CNT_MAX) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fsm_transition_monitor.sv
// Directed bench for fsm_transition_monitor; expectations follow FSM_MONITOR_TIMESTAMP_EN.
module tb_fsm_transition_monitor;

`ifdef FSM_MONITOR_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  state;
  logic [1:0]  next_state;
  logic        clear;
  logic        rec_valid;
  logic        rec_ready;
  logic [1:0]  rec_from;
  logic [1:0]  rec_to;
  logic [15:0] rec_delta;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        stuck;

  int n_cmp;
  int n_err;

  fsm_transition_monitor #(
    .STATE_W     (2),
    .DEPTH       (8),
    .TS_W        (16),
    .STUCK_LIMIT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .next_state (next_state),
    .clear      (clear),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_from   (rec_from),
    .rec_to     (rec_to),
    .rec_delta  (rec_delta),
    .overflow   (overflow),
    .drop_count (drop_count),
    .stuck      (stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input int f, input int t, input int d);
    check_eq({tag, "_valid"}, 32'(rec_valid), 32'd1);
    check_eq({tag, "_from"},  32'(rec_from),  32'(f));
    check_eq({tag, "_to"},    32'(rec_to),    32'(t));
    check_eq({tag, "_delta"}, 32'(rec_delta), TS_EN ? 32'(d) : 32'd0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; state = 2'd0; next_state = 2'd0; clear = 1'b0; rec_ready = 1'b0;
    tick; tick;
    check_eq("rst_valid",    32'(rec_valid),  32'd0);
    check_eq("rst_from",     32'(rec_from),   32'd0);
    check_eq("rst_to",       32'(rec_to),     32'd0);
    check_eq("rst_delta",    32'(rec_delta),  32'd0);
    check_eq("rst_overflow", 32'(overflow),   32'd0);
    check_eq("rst_drops",    32'(drop_count), 32'd0);
    check_eq("rst_stuck",    32'(stuck),      32'd0);

    // single transition 0->1 after a five-cycle dwell
    rst = 1'b0;
    tick; tick; tick; tick;
    check_eq("t1_idle_valid", 32'(rec_valid), 32'd0);
    next_state = 2'd1;
    tick;
    check_rec("t1_rec", 0, 1, 5);
    state = 2'd1; next_state = 2'd1; rec_ready = 1'b1;
    tick;
    check_eq("t1_popped", 32'(rec_valid), 32'd0);
    rec_ready = 1'b0;

    // ten back-to-back transitions into an 8-deep FIFO with no consumer
    rst = 1'b1; state = 2'd0; next_state = 2'd0;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      state = 2'(i); next_state = 2'(i + 1);
      tick;
    end
    check_rec("burst_head", 0, 1, 1);
    check_eq("burst_overflow", 32'(overflow),   32'd1);
    check_eq("burst_drops",    32'(drop_count), 32'd2);

    // push and pop together while full: accepted, no new drop
    state = 2'd2; next_state = 2'd3; rec_ready = 1'b1;
    tick;
    state = 2'd3; next_state = 2'd3;
    check_eq("fullpp_drops", 32'(drop_count), 32'd2);
    for (int k = 1; k < 8; k++) begin
      check_rec("drain", k % 4, (k + 1) % 4, 1);
      tick;
    end
    check_rec("drain_new", 2, 3, 1);
    tick;
    check_eq("drain_empty", 32'(rec_valid), 32'd0);
    rec_ready = 1'b0;

    // refill, then a drop on the same edge as clear
    for (int i = 0; i < 8; i++) begin
      state = 2'(i + 3); next_state = 2'(i + 4);
      tick;
    end
    check_eq("refill_drops", 32'(drop_count), 32'd2);
    state = 2'd3; next_state = 2'd0; clear = 1'b1;
    tick;
    check_eq("clrdrop_overflow", 32'(overflow),   32'd1);
    check_eq("clrdrop_drops",    32'(drop_count), 32'd1);
    state = 2'd0; next_state = 2'd0;
    tick;
    clear = 1'b0;
    check_eq("clr_overflow", 32'(overflow),   32'd0);
    check_eq("clr_drops",    32'(drop_count), 32'd0);
    check_eq("clr_valid",    32'(rec_valid),  32'd1);

    // stuck after 16 idle cycles, released by a 2->3 transition
    rst = 1'b1; state = 2'd2; next_state = 2'd2;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick;
    check_eq("stuck_early", 32'(stuck), 32'd0);
    tick;
    check_eq("stuck_set", 32'(stuck), TS_EN ? 32'd1 : 32'd0);
    next_state = 2'd3;
    tick;
    check_eq("stuck_release", 32'(stuck), 32'd0);
    check_rec("stuck_rec", 2, 3, 17);

    // three records buffered, then reset with a transition presented during it
    state = 2'd3; next_state = 2'd0;
    tick;
    state = 2'd0; next_state = 2'd1;
    tick;
    state = 2'd1; next_state = 2'd1;
    check_rec("mid_head", 2, 3, 17);
    rst = 1'b1; next_state = 2'd2;
    tick;
    rst = 1'b0; state = 2'd2; next_state = 2'd2;
    check_eq("midrst_valid",    32'(rec_valid),  32'd0);
    check_eq("midrst_from",     32'(rec_from),   32'd0);
    check_eq("midrst_overflow", 32'(overflow),   32'd0);
    check_eq("midrst_drops",    32'(drop_count), 32'd0);
    check_eq("midrst_stuck",    32'(stuck),      32'd0);
    tick;
    check_eq("midrst_norec", 32'(rec_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
